// File: rtl/fetch_pc_if_id.sv
// ============================================================================
// Module   : fetch_pc_if_id
// Brief    : Program counter and IF/ID pipeline register with stall, flush
//            and sticky illegal-fetch detection. Optional macro FETCH_COUNT_EN
//            enables the fetch_count counter of valid IF/ID loads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_if_id #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter int unsigned IM_WORDS  = 4096,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic [31:0] pc_add_4,
    input  logic [31:0] im_instr,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] F_pc,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pc_add_4,
    output logic        D_valid,
    output logic        fetch_err,
    output logic [31:0] fetch_err_pc,
    output logic [31:0] fetch_count
);

    // Bounds kept in 33 bits so PC_RESET + 4*IM_WORDS cannot wrap.
    localparam logic [32:0] c_PC_LO = {1'b0, PC_RESET};
    localparam logic [32:0] c_PC_HI = {1'b0, PC_RESET} + (33'(IM_WORDS) << 2);

    logic [31:0] r_f_pc;
    logic [31:0] r_d_instr;
    logic [31:0] r_d_pc;
    logic [31:0] r_d_pc_add_4;
    logic        r_d_valid;
    logic        r_fetch_err;
    logic [31:0] r_fetch_err_pc;
    logic        w_illegal;
    logic        w_load_valid;

    always_comb begin
        w_illegal = (r_f_pc[1:0] != 2'b00)
                 || ({1'b0, r_f_pc} < c_PC_LO)
                 || ({1'b0, r_f_pc} >= c_PC_HI);
        w_load_valid = !stall && !flush && !w_illegal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_f_pc       <= PC_RESET;
            r_d_instr    <= NOP_INSTR;
            r_d_pc       <= 32'h0;
            r_d_pc_add_4 <= 32'h0;
            r_d_valid    <= 1'b0;
        end else if (!stall) begin
            r_f_pc       <= next_pc;
            r_d_pc       <= r_f_pc;
            r_d_pc_add_4 <= pc_add_4;
            r_d_instr    <= w_load_valid ? im_instr : NOP_INSTR;
            r_d_valid    <= w_load_valid;
        end
    end

    // The error capture runs even while stalled: a frozen illegal PC is still illegal.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_err    <= 1'b0;
            r_fetch_err_pc <= 32'h0;
        end else if (w_illegal && !r_fetch_err) begin
            r_fetch_err    <= 1'b1;
            r_fetch_err_pc <= r_f_pc;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'h0;
        end else if (w_load_valid) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    assign fetch_count = 32'h0;
`endif

    assign F_pc         = r_f_pc;
    assign D_instr      = r_d_instr;
    assign D_pc         = r_d_pc;
    assign D_pc_add_4   = r_d_pc_add_4;
    assign D_valid      = r_d_valid;
    assign fetch_err    = r_fetch_err;
    assign fetch_err_pc = r_fetch_err_pc;

endmodule

`default_nettype wire
